// File: rtl/mul_eval_pkg.sv
// Shared types and widths for the approximate-multiplier error sweep.
package mul_eval_pkg;

    // Operand and product widths of the multiplier under evaluation.
    localparam int PKG_A_W = 6;
    localparam int PKG_B_W = 6;
    localparam int PKG_P_W = PKG_A_W + PKG_B_W;

    // Sweep counter covers every operand pair; the error counter needs one
    // more bit so that "every pair wrong" is representable.
    localparam int CNT_W  = PKG_A_W + PKG_B_W;
    localparam int ERRC_W = CNT_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // One evaluated operand pair, registered between the multiplier and the
    // accumulators.
    typedef struct packed {
        logic               valid;
        logic               neq;
        logic [PKG_P_W-1:0] abs_err;
        logic [PKG_A_W-1:0] a;
        logic [PKG_B_W-1:0] b;
    } stage_t;

endpackage

// File: rtl/mul_err_stage.sv
// Exact product, signed difference and absolute error for one operand pair,
// captured into a single pipeline register.
module mul_err_stage
    import mul_eval_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cap,
    input  logic [PKG_A_W-1:0] a,
    input  logic [PKG_B_W-1:0] b,
    input  logic [PKG_P_W-1:0] approx_p,
    output stage_t             stage_q
);

    logic [PKG_P_W-1:0] exact;
    logic [PKG_P_W:0]   diff;
    logic [PKG_P_W:0]   neg_diff;
    logic [PKG_P_W-1:0] abs_err;

    // Exact product and |approx - exact|; one extra bit keeps the sign.
    always_comb begin
        exact    = PKG_P_W'(a) * PKG_P_W'(b);
        diff     = {1'b0, approx_p} - {1'b0, exact};
        neg_diff = (PKG_P_W + 1)'(0) - diff;
        abs_err  = diff[PKG_P_W] ? neg_diff[PKG_P_W-1:0] : diff[PKG_P_W-1:0];
    end

    // Stage register: valid follows cap, so it is low outside the sweep.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples the
        // pre-edge values regardless of statement order.
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q.valid <= cap;
            if (cap) begin
                stage_q.neq     <= (approx_p != exact);
                stage_q.abs_err <= abs_err;
                stage_q.a       <= a;
                stage_q.b       <= b;
            end
        end
    end

endmodule

// File: rtl/mul_err_sweep.sv
// Exhaustive error-evaluation harness: walks every operand pair through an
// external combinational approximate multiplier and accumulates statistics.
module mul_err_sweep
    import mul_eval_pkg::*;
#(
    parameter int A_W   = 6,
    parameter int B_W   = 6,
    parameter int P_W   = 12,
    parameter int SUM_W = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [A_W-1:0]       op_a,
    output logic [B_W-1:0]       op_b,
    input  logic [P_W-1:0]       approx_p,
    output logic [A_W+B_W:0]     err_count,
    output logic [SUM_W-1:0]     sum_abs_err,
    output logic [P_W-1:0]       max_abs_err,
    output logic [A_W-1:0]       max_a,
    output logic [B_W-1:0]       max_b
);

    // The stage struct is sized from the package, so the parameters must
    // agree with it, and the product must be wide enough for a full a*b.
    if (P_W != A_W + B_W || A_W != PKG_A_W || B_W != PKG_B_W) begin : g_width_check
        $error("mul_err_sweep: P_W must equal A_W+B_W and match mul_eval_pkg");
    end

    state_t              state_q;
    logic                busy_q;
    logic                done_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ERRC_W-1:0]   err_cnt_q;
    logic [SUM_W-1:0]    sum_q;
    logic [SUM_W-1:0]    sum_d;
    logic [SUM_W:0]      sum_wide;
    logic [P_W-1:0]      max_q;
    logic [A_W-1:0]      max_a_q;
    logic [B_W-1:0]      max_b_q;
    stage_t              stage_q;

    assign op_a = cnt_q[CNT_W-1:B_W];
    assign op_b = cnt_q[B_W-1:0];

    mul_err_stage u_stage (
        .clk      (clk),
        .rst      (rst),
        .cap      (state_q == SWEEP),
        .a        (op_a),
        .b        (op_b),
        .approx_p (approx_p),
        .stage_q  (stage_q)
    );

    // Saturating add of the staged absolute error into the running sum.
    always_comb begin
        sum_wide = {1'b0, sum_q} + (SUM_W + 1)'(stage_q.abs_err);
        sum_d    = sum_wide[SUM_W] ? '1 : sum_wide[SUM_W-1:0];
    end

    // Sweep FSM, operand counter and error accumulators.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            err_cnt_q <= '0;
            sum_q     <= '0;
            max_q     <= '0;
            max_a_q   <= '0;
            max_b_q   <= '0;
        end else begin
            done_q <= 1'b0;

            if (stage_q.valid) begin
                err_cnt_q <= err_cnt_q + ERRC_W'(stage_q.neq);
                sum_q     <= sum_d;
                // Strictly greater keeps the earliest pair on ties.
                if (stage_q.abs_err > max_q) begin
                    max_q   <= stage_q.abs_err;
                    max_a_q <= stage_q.a;
                    max_b_q <= stage_q.b;
                end
            end

            // NOTE: every state_t value has an arm, so no default is needed
            // and no state can be left unhandled.
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= SWEEP;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        err_cnt_q <= '0;
                        sum_q     <= '0;
                        max_q     <= '0;
                        max_a_q   <= '0;
                        max_b_q   <= '0;
                    end
                end
                SWEEP: begin
                    if (cnt_q == '1) begin
                        state_q <= DRAIN;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err_count   = err_cnt_q;
    assign sum_abs_err = sum_q;
    assign max_abs_err = max_q;
    assign max_a       = max_a_q;
    assign max_b       = max_b_q;

endmodule

// File: tb/tb_mul_err_sweep.sv
// Directed bench for mul_err_sweep using stub multipliers and a truncated
// approximate multiplier with a bench-side golden model.
module tb_mul_err_sweep;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [5:0]  op_a;
    logic [5:0]  op_b;
    logic [11:0] approx_p;
    logic [12:0] err_count;
    logic [23:0] sum_abs_err;
    logic [11:0] max_abs_err;
    logic [5:0]  max_a;
    logic [5:0]  max_b;

    int total = 0;
    int bad   = 0;
    int mode  = 0;

    // Golden results for the truncated multiplier.
    longint g_err, g_sum, g_max, g_ma, g_mb;

    always #5 clk = ~clk;

    mul_err_sweep dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .op_a        (op_a),
        .op_b        (op_b),
        .approx_p    (approx_p),
        .err_count   (err_count),
        .sum_abs_err (sum_abs_err),
        .max_abs_err (max_abs_err),
        .max_a       (max_a),
        .max_b       (max_b)
    );

    // Approximate multiplier: drops partial products of weight below 2^3.
    function automatic logic [11:0] approx_mul(input logic [5:0] a, input logic [5:0] b);
        logic [11:0] acc;
        acc = '0;
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++)
                if (i + j >= 3 && a[i] && b[j])
                    acc = acc + (12'd1 << (i + j));
        return acc;
    endfunction

    // Multiplier stand-in selected by mode.
    always_comb begin
        case (mode)
            0:       approx_p = 12'(op_a) * 12'(op_b);
            1:       approx_p = (12'(op_a) * 12'(op_b)) & ~12'd1;
            2:       approx_p = 12'd0;
            default: approx_p = approx_mul(op_a, op_b);
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic golden();
        longint e, ex, ap;
        g_err = 0; g_sum = 0; g_max = 0; g_ma = 0; g_mb = 0;
        for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < 64; b++) begin
                ex = a * b;
                ap = longint'(approx_mul(6'(a), 6'(b)));
                e  = (ap > ex) ? ap - ex : ex - ap;
                if (e != 0) g_err++;
                g_sum += e;
                if (e > g_max) begin
                    g_max = e; g_ma = a; g_mb = b;
                end
            end
        end
    endtask

    // Pulse (or raise) start, count busy cycles and check the done pulse.
    task automatic run_sweep(input string tag, input bit hold_start);
        int  busy_cycles;
        bit  got_done;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        busy_cycles = 0;
        got_done    = 1'b0;
        for (int k = 0; k < 6000; k++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            @(negedge clk);
        end
        check({tag, "_done_seen"}, 64'(got_done), 64'd1);
        check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'd4097);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    endtask

    task automatic check_results(input string tag, input longint e, input longint s,
                                 input longint m, input longint ma, input longint mb);
        check({tag, "_err_count"}, 64'(err_count), 64'(e));
        check({tag, "_sum"},       64'(sum_abs_err), 64'(s));
        check({tag, "_max"},       64'(max_abs_err), 64'(m));
        check({tag, "_max_a"},     64'(max_a), 64'(ma));
        check({tag, "_max_b"},     64'(max_b), 64'(mb));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_op_a"}, 64'(op_a), 64'd0);
        check({tag, "_op_b"}, 64'(op_b), 64'd0);
        check_results(tag, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit reached;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_all_zero("reset");

        // Exact stub: no errors at all.
        mode = 0;
        run_sweep("exact", 1'b0);
        check_results("exact", 0, 0, 0, 0, 0);

        // LSB forced low: odd*odd pairs are off by one; first is (1,1).
        mode = 1;
        run_sweep("lsb0", 1'b0);
        check_results("lsb0", 1024, 1024, 1, 1, 1);
        repeat (5) @(negedge clk);
        check("lsb0_hold_err_count", 64'(err_count), 64'd1024);

        // All-zero product: every nonzero a*b is wrong.
        mode = 2;
        run_sweep("zero", 1'b0);
        check_results("zero", 3969, 4064256, 3969, 63, 63);

        // Truncated multiplier against the golden model, twice without reset.
        mode = 3;
        golden();
        run_sweep("trunc1", 1'b0);
        check_results("trunc1", g_err, g_sum, g_max, g_ma, g_mb);
        run_sweep("trunc2", 1'b0);
        check_results("trunc2", g_err, g_sum, g_max, g_ma, g_mb);

        // Reset in the middle of a sweep at cnt = 1000.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        reached = 1'b0;
        for (int k = 0; k < 6000; k++) begin
            if ({op_a, op_b} == 12'd1000) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("midrst_reached_1000", 64'(reached), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("midrst");
        @(negedge clk);
        check("midrst_stays_idle", 64'(busy), 64'd0);
        run_sweep("after_rst", 1'b0);
        check_results("after_rst", g_err, g_sum, g_max, g_ma, g_mb);

        // start held high: ignored while busy and in DONE, restarts from IDLE.
        mode = 2;
        run_sweep("held", 1'b1);
        check("held_idle_gap_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("held_restart_busy", 64'(busy), 64'd1);
        check("held_restart_op_a", 64'(op_a), 64'd0);
        start = 1'b0;
        reached = 1'b0;
        for (int k = 0; k < 6000; k++) begin
            if (done) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("held_second_done", 64'(reached), 64'd1);
        @(negedge clk);
        check("held_second_done_one_cycle", 64'(done), 64'd0);
        check_results("held", 3969, 4064256, 3969, 63, 63);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
